// File: rtl/core_pkg.sv
// Shared fetch-stage types: FSM state, buffer entry layout and instruction size.
package core_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fe_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fe_entry_t;

endpackage

// File: rtl/fe_fetch_fifo.sv
// In-order fetch buffer: entries are allocated at request acceptance, filled by
// responses in order, and popped from the head once filled.
module fe_fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        alloc,
  input  logic [31:0] alloc_pc,
  input  logic        fill,
  input  logic [31:0] fill_data,
  input  logic        pop,
  output logic [AW:0] alloc_cnt,
  output logic [AW:0] unfilled_cnt,
  output fe_entry_t   head
);

  fe_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] fill_ptr;
  logic [AW:0] rd_ptr;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign alloc_cnt    = wr_ptr - rd_ptr;
  assign unfilled_cnt = wr_ptr - fill_ptr;
  assign head         = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        mem[wr_ptr[AW-1:0]].pc     <= alloc_pc;
        mem[wr_ptr[AW-1:0]].filled <= 1'b0;
        wr_ptr                     <= wr_ptr + 1'b1;
      end
      if (fill) begin
        mem[fill_ptr[AW-1:0]].instr  <= fill_data;
        mem[fill_ptr[AW-1:0]].filled <= 1'b1;
        fill_ptr                     <= fill_ptr + 1'b1;
      end
      // Clearing filled on pop keeps a stale slot from reading as valid when empty.
      if (pop) begin
        mem[rd_ptr[AW-1:0]].filled <= 1'b0;
        rd_ptr                     <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fe_fetch_stage.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests, buffers returns
// and drains wrong-path responses after a redirect. Optional FE_PERF_CNT_EN adds counters.
module fe_fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        de_ready,
  output logic        fe_valid,
  output logic [31:0] fe_pc,
  output logic [31:0] fe_instr,
`ifdef FE_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt,
`endif
  output fe_state_e   dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready; valid never
  // depends combinationally on the same channel's ready.
  localparam int unsigned AW = $clog2(BUF_DEPTH);

  fe_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [AW:0] drop_q, drop_d;
  logic [AW:0] alloc_cnt, unfilled_cnt;
  fe_entry_t   head;
  logic        req_fire, fill, pop;

  assign imem_req_valid = rst && (state_q == RUN) && !redirect_valid
                          && (alloc_cnt < (AW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && (state_q == RUN);
  assign fe_valid       = head.filled;
  assign fe_pc          = head.pc;
  assign fe_instr       = head.instr;
  assign pop            = fe_valid && de_ready;
  assign dbg_state      = state_q;

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~32'h3;
      // In RUN drop_q is 0; in DRAIN the buffer is empty, so one sum covers both.
      drop_d = drop_q + unfilled_cnt - {{AW{1'b0}}, imem_rsp_valid};
    end else begin
      if (req_fire) pc_d = pc_q + 32'(INSTR_BYTES);
      if (state_q == DRAIN && imem_rsp_valid) drop_d = drop_q - 1'b1;
    end
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  fe_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush        (redirect_valid),
    .alloc        (req_fire),
    .alloc_pc     (pc_q),
    .fill         (fill),
    .fill_data    (imem_rsp_data),
    .pop          (pop),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt),
    .head         (head)
  );

`ifdef FE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (de_ready && !fe_valid) perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
    end
  end
`endif

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (unfilled_cnt != '0 || drop_q != '0))
    else $error("imem response with nothing outstanding");

  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst)
    fe_valid |-> (fe_pc[1:0] == 2'b00))
    else $error("misaligned fe_pc");

endmodule

// File: tb/tb_fe_fetch_stage.sv
// Randomized bench for fe_fetch_stage against an epoch-tagged transaction model.
module tb_fe_fetch_stage;
  import core_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        de_ready;
  logic        fe_valid;
  logic [31:0] fe_pc, fe_instr;
  fe_state_e   dbg_state;
`ifdef FE_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
  logic [31:0] exp_fetch_cnt, exp_bubble_cnt;
`endif

  fe_fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .de_ready       (de_ready),
    .fe_valid       (fe_valid),
    .fe_pc          (fe_pc),
    .fe_instr       (fe_instr),
`ifdef FE_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model and scoreboard state
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];      // accepted correct-path PCs not yet consumed
  int          filled_cur;    // how many of exp_q have returned data
  int unsigned epoch;
  int unsigned cyc;
  logic [31:0] exp_req;
  int unsigned lat_min, lat_max;
  int          checks, failures;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    exp_q.delete();
    filled_cur = 0;
    exp_req    = RESET_PC;
    epoch++;
`ifdef FE_PERF_CNT_EN
    exp_fetch_cnt  = '0;
    exp_bubble_cnt = '0;
`endif
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr",  imem_req_addr, RESET_PC);
    check("rst_fe_valid",  32'(fe_valid), 32'd0);
    check("rst_fe_pc",     fe_pc, 32'd0);
    check("rst_fe_instr",  fe_instr, 32'd0);
    check("rst_state",     32'(dbg_state), 32'(RUN));
  endtask

  // driver: one clock cycle of stimulus, checked at the falling edge
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy, input logic de);
    logic     rsp, exp_valid, pop, acc;
    int       stale;
    mem_req_t h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    de_ready       = de;
    rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? instr_of(mem_q[0].addr) : $urandom;
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    exp_valid = !rv && stale == 0 && exp_q.size() < DEPTH;

    @(negedge clk);
    check("req_addr",  imem_req_addr, exp_req);
    check("req_valid", 32'(imem_req_valid), 32'(exp_valid));
    check("fe_valid",  32'(fe_valid), 32'(filled_cur > 0));
    check("state",     32'(dbg_state), 32'(stale > 0 ? DRAIN : RUN));
    if (filled_cur > 0) begin
      check("fe_pc",    fe_pc, exp_q[0]);
      check("fe_instr", fe_instr, instr_of(exp_q[0]));
    end
`ifdef FE_PERF_CNT_EN
    check("perf_fetch",  perf_fetch_cnt, exp_fetch_cnt);
    check("perf_bubble", perf_bubble_cnt, exp_bubble_cnt);
    if (filled_cur > 0 && de) exp_fetch_cnt++;
    if (filled_cur == 0 && de) exp_bubble_cnt++;
`endif

    pop = (filled_cur > 0) && de;
    acc = exp_valid && rdy;
    if (imem_req_valid && rdy)
      mem_q.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_min, lat_max), epoch: epoch});
    if (rsp) begin
      h = mem_q.pop_front();
      if (h.epoch == epoch && !rv) filled_cur++;
    end
    if (rv) begin
      epoch++;
      exp_q.delete();
      filled_cur = 0;
      exp_req    = rpc & ~32'h3;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        filled_cur--;
      end
      if (acc) begin
        exp_q.push_back(exp_req);
        exp_req = exp_req + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mid_reset();
    rst = 1'b0;
    #1;
    check_reset_outputs();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    checks = 0; failures = 0; cyc = 0; epoch = 0;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; de_ready = 1'b0;
    model_reset();
    #2;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // streaming with 1-cycle memory
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b1);
    // decode stall then release
    repeat (5)  cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // redirect with two fetches in flight on a slow memory
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    check("two_in_flight", 32'(mem_q.size()), 32'd2);
    cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    repeat (15) cycle(1'b0, '0, 1'b1, 1'b1);

    // unaligned redirect target and address wrap
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 32'h0000_0203, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // reset while fetches are outstanding
    lat_min = 2; lat_max = 3;
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b1);
    mid_reset();
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        lat_min = 1;
        lat_max = $urandom_range(1, 4);
      end
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2:       rpc = 32'($urandom_range(0, 255));
        default: rpc = 32'h0000_0100;
      endcase
      cycle($urandom_range(0, 99) < 3, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (n == 1500) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
